// File: rtl/cmd_pkg.sv
// Command decoder shared definitions: ASCII command bytes,
// unknown-byte echo value and echo FSM state encoding.
package cmd_pkg;

  localparam logic [7:0] CH_R_UP = 8'h52;
  localparam logic [7:0] CH_R_LO = 8'h72;
  localparam logic [7:0] CH_C_UP = 8'h43;
  localparam logic [7:0] CH_C_LO = 8'h63;
  localparam logic [7:0] CH_M_UP = 8'h4D;
  localparam logic [7:0] CH_M_LO = 8'h6D;
  localparam logic [7:0] CH_U_UP = 8'h55;
  localparam logic [7:0] CH_U_LO = 8'h75;
  localparam logic [7:0] CH_UNK  = 8'h3F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } echo_state_t;

  function automatic logic is_cmd(
    input logic [7:0] b,
    input logic [7:0] up,
    input logic [7:0] lo
  );
    return (b == up) || (b == lo);
  endfunction

endpackage

// File: rtl/cmd_decoder_edge_detect.sv
// 1-bit rising-edge detector; history clears to 0 so a level
// held through reset yields one event after release.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prev <= 1'b0;
    else          r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/cmd_decoder.sv
// Button/UART command decoder driving counter controls,
// with a single-byte UART echo FSM.
module cmd_decoder (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_L,
  input  logic       btn_R,
  input  logic       btn_D,
  input  logic       btn_U,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       en,
  output logic       clear,
  output logic       mode,
  output logic       up_down
);

  import cmd_pkg::*;

  logic w_rise_l, w_rise_r, w_rise_d, w_rise_u;
  logic w_rx_r, w_rx_c, w_rx_m, w_rx_u, w_known;
  logic w_ev_run, w_ev_clr, w_ev_mode, w_ev_ud;
  logic w_tx_start;
  logic r_en, r_clear, r_mode, r_ud;
  logic [7:0] r_tx_data;
  echo_state_t r_state, w_next;

  edge_detect u_edge_l (
    .clk(clk), .reset_n(reset_n),
    .i_d(btn_L), .o_rise(w_rise_l)
  );
  edge_detect u_edge_r (
    .clk(clk), .reset_n(reset_n),
    .i_d(btn_R), .o_rise(w_rise_r)
  );
  edge_detect u_edge_d (
    .clk(clk), .reset_n(reset_n),
    .i_d(btn_D), .o_rise(w_rise_d)
  );
  edge_detect u_edge_u (
    .clk(clk), .reset_n(reset_n),
    .i_d(btn_U), .o_rise(w_rise_u)
  );

  assign w_rx_r = rx_done & is_cmd(rx_data, CH_R_UP, CH_R_LO);
  assign w_rx_c = rx_done & is_cmd(rx_data, CH_C_UP, CH_C_LO);
  assign w_rx_m = rx_done & is_cmd(rx_data, CH_M_UP, CH_M_LO);
  assign w_rx_u = rx_done & is_cmd(rx_data, CH_U_UP, CH_U_LO);
  assign w_known = w_rx_r | w_rx_c | w_rx_m | w_rx_u;

  // OR merges a button and UART hit on the same command
  assign w_ev_run  = w_rise_r | w_rx_r;
  assign w_ev_clr  = w_rise_d | w_rx_c;
  assign w_ev_mode = w_rise_l | w_rx_m;
  assign w_ev_ud   = w_rise_u | w_rx_u;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en    <= 1'b0;
      r_clear <= 1'b0;
      r_mode  <= 1'b0;
      r_ud    <= 1'b0;
    end else begin
      r_en    <= r_en ^ w_ev_run;
      r_clear <= w_ev_clr & ~r_en;
      r_mode  <= r_mode ^ w_ev_mode;
      r_ud    <= r_ud ^ w_ev_ud;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    unique case (r_state)
      S_IDLE: if (rx_done) w_next = S_SEND;
      S_SEND: begin
        if (!tx_busy) begin
          w_tx_start = 1'b1;
          w_next     = S_WAIT;
        end
      end
      S_WAIT: if (tx_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // echo byte only captured when idle; later bytes are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_data <= 8'h00;
    end else if (r_state == S_IDLE && rx_done) begin
      r_tx_data <= w_known ? rx_data : CH_UNK;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_start = w_tx_start;
  assign en       = r_en;
  assign clear    = r_clear;
  assign mode     = r_mode;
  assign up_down  = r_ud;

endmodule

// File: tb/tb_cmd_decoder.sv
// Scoreboard bench for cmd_decoder: reference model, UART
// transmitter emulator and decoupled output monitor.
module tb_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_L = 0, btn_R = 0, btn_D = 0, btn_U = 0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 0;
  logic       tx_busy;
  logic       tx_done = 0;
  logic [7:0] tx_data;
  logic       tx_start, en, clear, mode, up_down;

  logic       force_busy = 0;
  logic       em_busy = 0;
  int         em_cnt = 0;
  logic       start_seen = 0;

  int n_cmp = 0;
  int n_bad = 0;

  logic m_en, m_clr, m_mode, m_ud, m_fly;
  logic [3:0] m_prev;
  logic [7:0] exp_q[$];

  logic [7:0] cmds [8] = '{8'h52, 8'h72, 8'h43, 8'h63,
                           8'h4D, 8'h6D, 8'h55, 8'h75};

  assign tx_busy = em_busy | force_busy;

  always #5 clk = ~clk;

  cmd_decoder dut (
    .clk(clk), .reset_n(reset_n),
    .btn_L(btn_L), .btn_R(btn_R),
    .btn_D(btn_D), .btn_U(btn_U),
    .rx_data(rx_data), .rx_done(rx_done),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_data(tx_data), .tx_start(tx_start),
    .en(en), .clear(clear),
    .mode(mode), .up_down(up_down)
  );

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: commands as case-folded letters, echo as
  // "one byte in flight until the transmitter reports done".
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_en = 0; m_clr = 0; m_mode = 0; m_ud = 0;
      m_prev = 4'b0; m_fly = 0;
      exp_q.delete();
    end else begin
      logic [7:0] up;
      logic [3:0] b, rise;
      logic known;
      b    = {btn_L, btn_R, btn_D, btn_U};
      rise = b & ~m_prev;
      m_prev = b;
      up = rx_data & 8'hDF;
      known = 0;
      if (rx_done) known = (up == "R") || (up == "C") ||
                           (up == "M") || (up == "U");
      m_clr = (rise[1] || (rx_done && up == "C")) && !m_en;
      if (rise[2] || (rx_done && up == "R")) m_en = !m_en;
      if (rise[3] || (rx_done && up == "M")) m_mode = !m_mode;
      if (rise[0] || (rx_done && up == "U")) m_ud = !m_ud;
      if (rx_done && !m_fly) begin
        exp_q.push_back(known ? rx_data : 8'h3F);
        m_fly = 1;
      end
      if (tx_done) m_fly = 0;
    end
  end

  // UART transmitter stand-in, driven just after each edge
  always @(posedge clk) begin
    #1;
    tx_done = 0;
    if (!reset_n) begin
      em_busy = 0;
      em_cnt  = 0;
    end else begin
      if (em_cnt > 0) begin
        em_cnt--;
        if (em_cnt == 0) begin
          tx_done = 1;
          em_busy = 0;
        end
      end
      if (start_seen) begin
        em_busy = 1;
        em_cnt  = $urandom_range(1, 6);
      end
    end
  end

  always @(negedge clk) begin
    chk("en", {7'b0, en}, {7'b0, m_en});
    chk("clear", {7'b0, clear}, {7'b0, m_clr});
    chk("mode", {7'b0, mode}, {7'b0, m_mode});
    chk("up_down", {7'b0, up_down}, {7'b0, m_ud});
    if (tx_start) begin
      chk("start_while_busy", {7'b0, tx_busy}, 8'h00);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_tx_start: got 1 want 0 at %0t",
                 $time);
      end else begin
        chk("tx_data", tx_data, exp_q.pop_front());
      end
    end
    start_seen = tx_start && reset_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    btn_L = 0; btn_R = 0; btn_D = 0; btn_U = 0;
    rx_done = 0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1;
    tick();
    rx_done = 0;
    rx_data = $urandom;
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #3;
    reset_n = 0;
    #1;
    chk("rst_en", {7'b0, en}, 8'h00);
    chk("rst_clear", {7'b0, clear}, 8'h00);
    chk("rst_mode", {7'b0, mode}, 8'h00);
    chk("rst_ud", {7'b0, up_down}, 8'h00);
    chk("rst_tx_start", {7'b0, tx_start}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    repeat (hold) @(posedge clk);
    #3;
    reset_n = 1;
    tick();
  endtask

  task automatic drain();
    int k;
    idle_in();
    k = 0;
    while ((m_fly || exp_q.size() != 0) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               exp_q.size());
    end
  endtask

  task automatic rand_run(input int n, input bit rst_ok);
    for (int i = 0; i < n; i++) begin
      int sel;
      if ($urandom_range(0, 5) == 0) btn_L = ~btn_L;
      if ($urandom_range(0, 5) == 0) btn_R = ~btn_R;
      if ($urandom_range(0, 5) == 0) btn_D = ~btn_D;
      if ($urandom_range(0, 5) == 0) btn_U = ~btn_U;
      sel = $urandom_range(0, 9);
      rx_data = (sel < 8) ? cmds[sel] : 8'($urandom);
      rx_done = ($urandom_range(0, 5) == 0);
      if (rst_ok && $urandom_range(0, 299) == 0)
        do_reset($urandom_range(2, 4));
      else
        tick();
    end
    idle_in();
  endtask

  initial begin
    int k;
    #2;
    do_reset(3);

    btn_R = 1;
    repeat (1000) tick();
    btn_R = 0;
    tick();

    btn_D = 1; tick(); btn_D = 0; tick();
    btn_R = 1; tick(); btn_R = 0; tick();
    btn_D = 1; tick(); btn_D = 0; tick();

    send(8'h6D);
    drain();
    send(8'h41);
    drain();

    rand_run(3000, 0);
    drain();

    force_busy = 1;
    send(8'h55);
    repeat (9) tick();
    send(8'h55);
    repeat (39) tick();
    force_busy = 0;
    drain();

    btn_L = 1;
    send(8'h4D);
    btn_L = 0;
    drain();

    send(8'h52);
    k = 0;
    while (!start_seen && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL start_timeout: got 0 want 1");
    end
    tick();
    btn_U = 1;
    do_reset(3);
    repeat (10) tick();
    btn_U = 0;

    rand_run(2000, 1);
    drain();
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
